// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared SIMD widths, ALU op codes and writeback entry type
package simd_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int RA_W   = 4;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_ADD = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_MUL = 4'b0111,
        ALU_DIV = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic [VEC_W-1:0] data;
        logic             zero;
        logic [RA_W-1:0]  rd;
        logic [LANES-1:0] mask;
        logic [LANES-1:0] lane_zero;
    } wb_entry_t;

    function automatic logic [LANES-1:0] lane_zero_of(input logic [VEC_W-1:0] v);
        logic [LANES-1:0] z;
        for (int i = 0; i < LANES; i++) begin
            z[i] = (v[i*LANE_W +: LANE_W] == '0);
        end
        return z;
    endfunction

endpackage

// File: rtl/simd_wb_fifo.sv
// rtl/simd_wb_fifo.sv - in-order wb_entry_t FIFO exposing occupancy and valid slots
module simd_wb_fifo
    import simd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  wr_entry,
    output wb_entry_t                  head,
    output wb_entry_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]           slot_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      off;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload is not reset; slot_valid alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    always_comb begin
        slot_valid = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PTR_W'(i) - rd_ptr;
            slot_valid[i] = (CNT_W'(off) < count);
        end
    end

endmodule

// File: rtl/simd_result_writeback.sv
// rtl/simd_result_writeback.sv - buffers SIMD ALU results and drains them to the VRF write port
module simd_result_writeback
    import simd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VEC_W-1:0]       in_result,
    input  logic                   in_zero,
    input  logic [RA_W-1:0]        in_rd,
    input  logic [LANES-1:0]       in_lane_mask,
    output logic                   wb_en,
    output logic [RA_W-1:0]        wb_addr,
    output logic [VEC_W-1:0]       wb_data,
    output logic [LANES-1:0]       wb_lane_we,
    input  logic                   wb_stall,
    input  logic [RA_W-1:0]        hz_addr,
    output logic                   hz_hit,
    output logic                   zero_flag_q,
    output logic [LANES-1:0]       lane_zero_q,
    output logic [$clog2(DEPTH):0] count
);

    wb_entry_t             wr_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      slot_valid;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // in_ready depends on stored occupancy only, so a full buffer refuses even on a pop cycle.
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign wb_en    = ~empty;
    assign pop      = wb_en & ~wb_stall;

    assign wr_entry = '{data:      in_result,
                        zero:      in_zero,
                        rd:        in_rd,
                        mask:      in_lane_mask,
                        lane_zero: lane_zero_of(in_result)};

    simd_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .head       (head),
        .entries    (entries),
        .slot_valid (slot_valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign wb_addr    = head.rd;
    assign wb_data    = head.data;
    assign wb_lane_we = head.mask & {LANES{wb_en}};

    // Entries with an empty lane mask write nothing, so they cannot create a RAW hazard.
    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (entries[i].rd == hz_addr) && (|entries[i].mask)) begin
                hz_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_flag_q <= 1'b0;
            lane_zero_q <= '0;
        end else if (pop) begin
            zero_flag_q <= head.zero;
            lane_zero_q <= head.lane_zero;
        end
    end

endmodule

// File: tb/tb_simd_result_writeback.sv
// tb/tb_simd_result_writeback.sv - directed and random checks against a queue model
module tb_simd_result_writeback;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_result;
    logic         in_zero;
    logic [3:0]   in_rd;
    logic [3:0]   in_lane_mask;
    logic         wb_en;
    logic [3:0]   wb_addr;
    logic [127:0] wb_data;
    logic [3:0]   wb_lane_we;
    logic         wb_stall;
    logic [3:0]   hz_addr;
    logic         hz_hit;
    logic         zero_flag_q;
    logic [3:0]   lane_zero_q;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        logic         zero;
        logic [3:0]   rd;
        logic [3:0]   mask;
    } ent_t;

    ent_t       q[$];
    logic       m_zf;
    logic [3:0] m_lz;

    always #5 clk = ~clk;

    simd_result_writeback #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_rd        (in_rd),
        .in_lane_mask (in_lane_mask),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_lane_we   (wb_lane_we),
        .wb_stall     (wb_stall),
        .hz_addr      (hz_addr),
        .hz_hit       (hz_hit),
        .zero_flag_q  (zero_flag_q),
        .lane_zero_q  (lane_zero_q),
        .count        (count)
    );

    function automatic logic [3:0] zeros_of(input logic [127:0] d);
        logic [3:0] z;
        for (int l = 0; l < 4; l++) z[l] = (d[32*l +: 32] == 32'd0);
        return z;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic hz_exp;
        hz_exp = 1'b0;
        foreach (q[k]) if (q[k].rd == hz_addr && q[k].mask != 4'd0) hz_exp = 1'b1;
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("count", count, q.size());
        chk("wb_en", wb_en, q.size() != 0);
        if (q.size() != 0) begin
            chk("wb_addr", wb_addr, q[0].rd);
            chk("wb_data", wb_data, q[0].data);
            chk("wb_lane_we", wb_lane_we, q[0].mask);
        end else begin
            chk("wb_lane_we_idle", wb_lane_we, 4'd0);
        end
        chk("hz_hit", hz_hit, hz_exp);
        chk("zero_flag_q", zero_flag_q, m_zf);
        chk("lane_zero_q", lane_zero_q, m_lz);
    endtask

    task automatic model_edge();
        ent_t e;
        bit   do_pop;
        bit   do_push;
        if (!rst_n) begin
            q.delete();
            m_zf = 1'b0;
            m_lz = 4'd0;
        end else begin
            do_pop  = (q.size() != 0) && !wb_stall;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) begin
                e    = q.pop_front();
                m_zf = e.zero;
                m_lz = zeros_of(e.data);
            end
            if (do_push) begin
                e.data = in_result;
                e.zero = in_zero;
                e.rd   = in_rd;
                e.mask = in_lane_mask;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] res, input logic [3:0] rd,
                         input logic [3:0] mask, input logic stall, input logic [3:0] hz);
        in_valid     = v;
        in_result    = res;
        in_zero      = (res[31:0] == 32'd0);
        in_rd        = rd;
        in_lane_mask = mask;
        wb_stall     = stall;
        hz_addr      = hz;
        cycle();
    endtask

    function automatic logic [127:0] rnd_vec();
        logic [127:0] v;
        for (int l = 0; l < 4; l++)
            v[32*l +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        return v;
    endfunction

    initial begin
        m_zf = 1'b0;
        m_lz = 4'd0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_result = 128'h1;
        in_zero = 1'b0;
        in_rd = 4'd1;
        in_lane_mask = 4'hF;
        wb_stall = 1'b0;
        hz_addr = 4'd0;

        // 1: reset held three edges with in_valid high
        repeat (3) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst_count", count, 3'd0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_zero_flag", zero_flag_q, 1'b0);

        // 2: pass-through
        drive(1, 128'h4_0000_0003_0000_0000_0000_0007, 4'd5, 4'hF, 0, 4'd5);
        drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd5);
        drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd5);

        // 3: fill under stall, fifth push refused, then drain
        for (int i = 1; i <= 4; i++) drive(1, rnd_vec(), 4'(i), 4'hF, 1, 4'(i));
        drive(1, rnd_vec(), 4'd5, 4'hF, 1, 4'd5);
        drive(1, rnd_vec(), 4'd5, 4'hF, 1, 4'd5);
        for (int i = 0; i < 6; i++) drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd5);

        // 4: steady push+pop at occupancy two
        drive(1, rnd_vec(), 4'd8, 4'h3, 1, 4'd8);
        drive(1, rnd_vec(), 4'd9, 4'hC, 1, 4'd9);
        for (int i = 0; i < 6; i++) drive(1, rnd_vec(), 4'(10 + i), 4'(i + 1), 0, 4'(9 + i));
        for (int i = 0; i < 3; i++) drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd0);

        // 5: hazard detection, empty-mask entries never hit
        drive(1, rnd_vec(), 4'd3, 4'h2, 1, 4'd3);
        drive(1, rnd_vec(), 4'd7, 4'h0, 1, 4'd3);
        drive(0, 128'h0, 4'd0, 4'h0, 1, 4'd3);
        drive(0, 128'h0, 4'd0, 4'h0, 1, 4'd7);
        drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd3);
        drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd3);
        drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd7);

        // 6: reset while draining
        for (int i = 0; i < 3; i++) drive(1, rnd_vec(), 4'(i + 2), 4'hF, 1, 4'd2);
        wb_stall = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_lane_zero", lane_zero_q, 4'd0);
        chk("mid_rst_count", count, 3'd0);
        for (int i = 0; i < 3; i++) drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd2);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), rnd_vec(), 4'($urandom),
                  ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) drive(0, 128'h0, 4'd0, 4'h0, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
